// File: rtl/muldiv_sequencer_if.sv
// Request/result handshake and ALU drive bundle for the iterative mul/div sequencer.
interface muldiv_sequencer_if;
  logic        req_i;
  logic [1:0]  op_i;
  logic [63:0] opa_i;
  logic [63:0] opb_i;
  logic        abort_i;
  logic        ack_i;
  logic        busy_o;
  logic        valid_o;
  logic [63:0] result_o;
  logic [63:0] alu_inA_o;
  logic [63:0] alu_inB_o;
  logic        alu_cflag_o;
  logic        alu_sum_en_o;
  logic        alu_invB_en_o;
  logic        alu_and_en_o;
  logic        alu_xor_en_o;
  logic        alu_lsh_en_o;
  logic        alu_rsh_en_o;
  logic [63:0] alu_out_i;
  logic        alu_cflag_i;

  // Execute stage and shared ALU side.
  modport master (
    output req_i, op_i, opa_i, opb_i, abort_i, ack_i, alu_out_i, alu_cflag_i,
    input  busy_o, valid_o, result_o, alu_inA_o, alu_inB_o, alu_cflag_o, alu_sum_en_o,
           alu_invB_en_o, alu_and_en_o, alu_xor_en_o, alu_lsh_en_o, alu_rsh_en_o
  );

  // Sequencer side.
  modport slave (
    input  req_i, op_i, opa_i, opb_i, abort_i, ack_i, alu_out_i, alu_cflag_i,
    output busy_o, valid_o, result_o, alu_inA_o, alu_inB_o, alu_cflag_o, alu_sum_en_o,
           alu_invB_en_o, alu_and_en_o, alu_xor_en_o, alu_lsh_en_o, alu_rsh_en_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 64-bit unsigned multiply/divide controller borrowing the core's shared ALU.
// One bit per cycle for 64 cycles: shift-and-add multiply, restoring divide.
module muldiv_sequencer (
  input logic               clk_i,
  input logic               reset_i,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRemu = 2'b10;

  logic [1:0]  state_q;
  logic [63:0] acc_q;
  logic [63:0] x_q;
  logic [63:0] y_q;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [63:0] result_q;

  logic        is_div;
  logic        load_div;
  logic [63:0] shifted;
  logic        take;
  logic [63:0] acc_step;
  logic [63:0] x_step;
  logic [63:0] y_step;

  assign is_div   = (op_q == OpDivu) || (op_q == OpRemu);
  assign load_div = (bus.op_i == OpDivu) || (bus.op_i == OpRemu);
  // Partial remainder shifted left with the next dividend bit brought in.
  assign shifted  = {acc_q[62:0], y_q[63]};
  // acc[63] set means the real 65-bit partial remainder exceeds any divisor.
  assign take     = bus.alu_cflag_i | acc_q[63];

  // ALU operand/control drive; everything is zero outside RUN so the core can OR in its own.
  always_comb begin
    bus.alu_inA_o     = '0;
    bus.alu_inB_o     = '0;
    bus.alu_cflag_o   = 1'b0;
    bus.alu_sum_en_o  = 1'b0;
    bus.alu_invB_en_o = 1'b0;
    if (state_q == StRun) begin
      bus.alu_inB_o    = x_q;
      bus.alu_sum_en_o = 1'b1;
      if (is_div) begin
        bus.alu_inA_o     = shifted;
        bus.alu_invB_en_o = 1'b1;
        bus.alu_cflag_o   = 1'b1;
      end else begin
        bus.alu_inA_o = acc_q;
      end
    end
  end

  assign bus.alu_and_en_o = 1'b0;
  assign bus.alu_xor_en_o = 1'b0;
  assign bus.alu_lsh_en_o = 1'b0;
  assign bus.alu_rsh_en_o = 1'b0;

  // Next values of the datapath registers for one multiply or divide step.
  always_comb begin
    if (is_div) begin
      acc_step = take ? bus.alu_out_i : shifted;
      x_step   = x_q;
      y_step   = {y_q[62:0], take};
    end else begin
      acc_step = y_q[0] ? bus.alu_out_i : acc_q;
      x_step   = x_q << 1;
      y_step   = y_q >> 1;
    end
  end

  // Control FSM and datapath registers; abort overrides everything, ack beats req.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else if (bus.abort_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_i) begin
            acc_q   <= '0;
            x_q     <= load_div ? bus.opb_i : bus.opa_i;
            y_q     <= load_div ? bus.opa_i : bus.opb_i;
            cnt_q   <= 6'd63;
            op_q    <= bus.op_i;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_step;
          x_q   <= x_step;
          y_q   <= y_step;
          if (cnt_q == 6'd0) begin
            state_q  <= StDone;
            result_q <= (op_q == OpDivu) ? y_step : acc_step;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        StDone: begin
          if (bus.ack_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != StIdle);
  assign bus.valid_o  = (state_q == StDone);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a combinational ALU model and a result scoreboard.
module tb_muldiv_sequencer;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // Shared ALU: sum with optional inverted B and carry-in.
  logic [64:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_inA_o}
                 + {1'b0, (bus.alu_invB_en_o ? ~bus.alu_inB_o : bus.alu_inB_o)}
                 + {64'd0, bus.alu_cflag_o};
  assign bus.alu_out_i   = bus.alu_sum_en_o ? alu_sum[63:0] : 64'd0;
  assign bus.alu_cflag_i = bus.alu_sum_en_o & alu_sum[64];

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    case (op)
      2'b01:   model = (b == 64'd0) ? {64{1'b1}} : a / b;
      2'b10:   model = (b == 64'd0) ? a : a % b;
      default: model = a * b;
    endcase
  endfunction

  // Called at a negedge in IDLE. Result appears after the 64th edge following accept,
  // i.e. on the 65th negedge counted from the accept edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int hold_done, input bit hold_req);
    int          lat;
    int          busy_cnt;
    logic [63:0] r;
    logic [63:0] exp;
    sb_q.push_back(model(op, a, b));
    bus.req_i = 1'b1;
    bus.op_i  = op;
    bus.opa_i = a;
    bus.opb_i = b;
    @(negedge clk_i);
    if (!hold_req) bus.req_i = 1'b0;
    check({tag, " run sum_en"}, 64'(bus.alu_sum_en_o), 64'd1);
    check({tag, " run invB"}, 64'(bus.alu_invB_en_o), 64'((op == 2'b01) || (op == 2'b10)));
    check({tag, " run inB"}, bus.alu_inB_o, ((op == 2'b01) || (op == 2'b10)) ? b : a);
    lat = 1;
    busy_cnt = 0;
    while (!bus.valid_o && lat < 100) begin
      if (bus.busy_o) busy_cnt++;
      @(negedge clk_i);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd65);
    check({tag, " busy run cycles"}, 64'(busy_cnt), 64'd64);
    check({tag, " busy done"}, 64'(bus.busy_o), 64'd1);
    r = bus.result_o;
    for (int i = 0; i < hold_done; i++) begin
      @(negedge clk_i);
      check({tag, " hold valid"}, 64'(bus.valid_o), 64'd1);
      check({tag, " hold result"}, bus.result_o, r);
    end
    exp = sb_q.pop_front();
    check({tag, " result"}, bus.result_o, exp);
    bus.ack_i = 1'b1;
    bus.req_i = 1'b0;
    @(negedge clk_i);
    bus.ack_i = 1'b0;
    check({tag, " valid after ack"}, 64'(bus.valid_o), 64'd0);
    check({tag, " busy after ack"}, 64'(bus.busy_o), 64'd0);
    check({tag, " idle sum_en"}, 64'(bus.alu_sum_en_o), 64'd0);
    if (hold_req) begin
      busy_cnt = 0;
      repeat (3) begin
        @(negedge clk_i);
        if (bus.busy_o) busy_cnt++;
      end
      check({tag, " no re-accept"}, 64'(busy_cnt), 64'd0);
    end
  endtask

  initial begin
    int          vcnt;
    logic [63:0] r;
    reset_i     = 1'b1;
    bus.req_i   = 1'b0;
    bus.op_i    = 2'b00;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.abort_i = 1'b0;
    bus.ack_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset valid", 64'(bus.valid_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    check("reset inA", bus.alu_inA_o, 64'd0);
    check("reset inB", bus.alu_inB_o, 64'd0);
    check("reset ctl", 64'({bus.alu_cflag_o, bus.alu_sum_en_o, bus.alu_invB_en_o,
                            bus.alu_and_en_o, bus.alu_xor_en_o, bus.alu_lsh_en_o,
                            bus.alu_rsh_en_o}), 64'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    run_op("mulu 3x5", 2'b00, 64'd3, 64'd5, 0, 1'b0);
    run_op("mulu ones", 2'b00, {64{1'b1}}, {64{1'b1}}, 0, 1'b0);
    run_op("mulu by 0", 2'b00, 64'h1234_5678, 64'd0, 0, 1'b0);
    run_op("divu 100/7", 2'b01, 64'd100, 64'd7, 0, 1'b0);
    run_op("remu 100%7", 2'b10, 64'd100, 64'd7, 0, 1'b0);
    run_op("divu big", 2'b01, {64{1'b1}}, 64'h8000_0000_0000_0001, 0, 1'b0);
    run_op("remu big", 2'b10, {64{1'b1}}, 64'h8000_0000_0000_0001, 0, 1'b0);
    run_op("divu by 0", 2'b01, 64'h1234, 64'd0, 0, 1'b0);
    run_op("remu by 0", 2'b10, 64'h1234, 64'd0, 0, 1'b0);
    run_op("rsvd op", 2'b11, 64'd9, 64'd13, 0, 1'b0);

    // Abort at RUN cycle 20: back to IDLE, no valid pulse, result holds.
    r = bus.result_o;
    bus.req_i = 1'b1;
    bus.op_i  = 2'b01;
    bus.opa_i = 64'd5000;
    bus.opb_i = 64'd3;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    repeat (19) @(negedge clk_i);
    bus.abort_i = 1'b1;
    @(negedge clk_i);
    bus.abort_i = 1'b0;
    check("abort busy", 64'(bus.busy_o), 64'd0);
    check("abort valid", 64'(bus.valid_o), 64'd0);
    check("abort result hold", bus.result_o, r);
    vcnt = 0;
    repeat (70) begin
      @(negedge clk_i);
      if (bus.valid_o || bus.busy_o) vcnt++;
    end
    check("abort no valid", 64'(vcnt), 64'd0);
    run_op("mulu 6x7", 2'b00, 64'd6, 64'd7, 0, 1'b0);

    run_op("req held", 2'b00, 64'd9, 64'd11, 0, 1'b1);
    run_op("ack late", 2'b01, 64'd1000, 64'd33, 10, 1'b0);

    // Asynchronous reset mid-RUN takes effect before the next clock edge.
    bus.req_i = 1'b1;
    bus.op_i  = 2'b01;
    bus.opa_i = 64'd777;
    bus.opb_i = 64'd5;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("pre-reset busy", 64'(bus.busy_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check("async rst busy", 64'(bus.busy_o), 64'd0);
    check("async rst valid", 64'(bus.valid_o), 64'd0);
    check("async rst ctl", 64'({bus.alu_cflag_o, bus.alu_sum_en_o, bus.alu_invB_en_o}), 64'd0);
    check("async rst inA", bus.alu_inA_o, 64'd0);
    check("async rst result", bus.result_o, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post-reset busy", 64'(bus.busy_o), 64'd0);
    run_op("recover", 2'b10, 64'd777, 64'd5, 0, 1'b0);

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
